// File: rtl/mdu_e.sv
// rtl/mdu_e.sv - MIPS EX-stage multiply/divide unit with HI/LO registers
// Result is computed at accept time and held pending until the latency counter expires.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pok_q, pok_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        a_mag, b_mag, mq, mr, sq, sr, uq, ur;
  logic               b_zero;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps instead of trapping.
  always_comb begin
    smul   = $signed(a) * $signed(b);
    umul   = {32'd0, a} * {32'd0, b};
    b_zero = (b == 32'd0);
    a_mag  = a[31] ? (32'd0 - a) : a;
    b_mag  = b[31] ? (32'd0 - b) : b;
    mq     = b_zero ? 32'd0 : (a_mag / b_mag);
    mr     = b_zero ? 32'd0 : (a_mag % b_mag);
    sq     = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
    sr     = a[31] ? (32'd0 - mr) : mr;
    uq     = b_zero ? 32'd0 : (a / b);
    ur     = b_zero ? 32'd0 : (a % b);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pok_d   = pok_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      phi_d   = 32'd0;
      plo_d   = 32'd0;
      pok_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {phi_d, plo_d} = smul;
                pok_d   = 1'b1;
                cnt_d   = CW'(MULT_CYCLES);
                state_d = RUN;
              end
              OP_MULTU: begin
                {phi_d, plo_d} = umul;
                pok_d   = 1'b1;
                cnt_d   = CW'(MULT_CYCLES);
                state_d = RUN;
              end
              OP_DIV: begin
                phi_d   = sr;
                plo_d   = sq;
                pok_d   = !b_zero;
                cnt_d   = CW'(DIV_CYCLES);
                state_d = RUN;
              end
              OP_DIVU: begin
                phi_d   = ur;
                plo_d   = uq;
                pok_d   = !b_zero;
                cnt_d   = CW'(DIV_CYCLES);
                state_d = RUN;
              end
              OP_MTHI: hi_d = a;
              OP_MTLO: lo_d = a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            if (pok_q) begin
              hi_d = phi_q;
              lo_d = plo_q;
            end
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pok_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pok_q   <= pok_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
